tick_scheduler: RTL and testbench

//   Core-side consumer of the merged local-in packet stream. Each packet {dt, axon} sets one

---
 rtl/tick_scheduler.sv | 113 +++++++++++
 tb/tb_tick_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// -----------------------------------------------------------------------------
// tick_scheduler
//
// Core-side consumer of the merged local-in packet stream. Each packet carries
// a delay (dt) and an axon index. The axon bit is set in a circular bank of
// per-tick spike rows, dt rows ahead of the current row pointer. On every
// global tick the current row is emitted as the axon spike vector for the
// neuron block, the row is cleared, and the pointer advances by one (wrapping).
// One packet is accepted per cycle; there is no backpressure.
//
// Parameters
//   PACKET_WIDTH : packet width, must equal DT_WIDTH + AXON_WIDTH
//   DT_WIDTH     : delay field width; NUM_SLOTS = 2**DT_WIDTH rows
//   AXON_WIDTH   : axon index width; NUM_AXONS = 2**AXON_WIDTH bits per row
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-low reset
//   din          : packet {dt, axon}
//   din_wen      : packet valid this cycle (always accepted)
//   tick         : one-cycle global tick strobe
//   axons_out    : registered spike vector for the most recent tick
//   axons_valid  : one-cycle pulse the cycle after a tick
//   ptr_out      : current row pointer
// -----------------------------------------------------------------------------
module tick_scheduler #(
    parameter int PACKET_WIDTH = 12,
    parameter int DT_WIDTH     = 4,
    parameter int AXON_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PACKET_WIDTH-1:0]    din,
    input  logic                       din_wen,
    input  logic                       tick,
    output logic [(1<<AXON_WIDTH)-1:0] axons_out,
    output logic                       axons_valid,
    output logic [DT_WIDTH-1:0]        ptr_out
);

    localparam int NUM_SLOTS = 1 << DT_WIDTH;
    localparam int NUM_AXONS = 1 << AXON_WIDTH;

    // A packet whose fields do not exactly fill it would silently lose bits.
    if (PACKET_WIDTH != DT_WIDTH + AXON_WIDTH) begin : g_width_check
        $error("tick_scheduler: PACKET_WIDTH must equal DT_WIDTH + AXON_WIDTH");
    end

    // Row index dt ticks ahead of the pointer; the DT_WIDTH-bit add wraps
    // naturally around the circular bank.
    function automatic logic [DT_WIDTH-1:0] slot_target(
        input logic [DT_WIDTH-1:0] base,
        input logic [DT_WIDTH-1:0] delay
    );
        return base + delay;
    endfunction

    function automatic logic [NUM_AXONS-1:0] axon_onehot(
        input logic [AXON_WIDTH-1:0] idx
    );
        return NUM_AXONS'(1) << idx;
    endfunction

    logic [NUM_AXONS-1:0]  rows [NUM_SLOTS];
    logic [DT_WIDTH-1:0]   ptr;

    logic [DT_WIDTH-1:0]   pkt_dt;
    logic [AXON_WIDTH-1:0] pkt_axon;
    logic [DT_WIDTH-1:0]   target;
    logic [NUM_AXONS-1:0]  pkt_bit;
    logic                  same_row_bypass;

    assign pkt_dt   = din[PACKET_WIDTH-1 -: DT_WIDTH];
    assign pkt_axon = din[AXON_WIDTH-1:0];
    assign target   = slot_target(ptr, pkt_dt);
    assign pkt_bit  = axon_onehot(pkt_axon);

    // A dt==0 packet arriving with the tick targets the row being emitted and
    // cleared; it must ride out with this tick rather than land in the
    // freshly cleared row (which would delay it by a full rotation).
    assign same_row_bypass = tick && din_wen && (target == ptr);

    assign ptr_out = ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                rows[s] <= '0;
            end
            ptr         <= '0;
            axons_out   <= '0;
            axons_valid <= 1'b0;
        end else begin
            axons_valid <= tick;

            if (tick) begin
                axons_out <= rows[ptr] | (same_row_bypass ? pkt_bit : '0);
                ptr       <= ptr + 1'b1;
            end

            // Clearing the emitted row takes priority over a packet write to
            // the same row; that packet is covered by the bypass above.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (tick && (DT_WIDTH'(s) == ptr)) begin
                    rows[s] <= '0;
                end else if (din_wen && (DT_WIDTH'(s) == target)) begin
                    rows[s] <= rows[s] | pkt_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    logic         clk;
    logic         rst;
    logic [11:0]  din;
    logic         din_wen;
    logic         tick;
    logic [255:0] axons_out;
    logic         axons_valid;
    logic [3:0]   ptr_out;

    int n_checks;
    int n_fail;

    tick_scheduler #(
        .PACKET_WIDTH(12),
        .DT_WIDTH    (4),
        .AXON_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_wen    (din_wen),
        .tick       (tick),
        .axons_out  (axons_out),
        .axons_valid(axons_valid),
        .ptr_out    (ptr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] bitv(input int a);
        logic [255:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] pkt(input int dt, input int axon);
        logic [3:0] d;
        logic [7:0] a;
        d = 4'(dt);
        a = 8'(axon);
        return {d, a};
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic t, input logic w, input logic [11:0] d);
        tick    = t;
        din_wen = w;
        din     = d;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        din_wen = 1'b0;
        din     = '0;
    endtask

    task automatic tick_check(input string tag, input logic [255:0] exp_out, input int exp_ptr);
        step(1'b1, 1'b0, '0);
        check({tag, "_valid"}, {255'd0, axons_valid}, 256'd1);
        check({tag, "_out"}, axons_out, exp_out);
        check({tag, "_ptr"}, {252'd0, ptr_out}, 256'(exp_ptr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        tick     = 1'b0;
        din_wen  = 1'b0;
        din      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        check("rst_out", axons_out, '0);
        check("rst_valid", {255'd0, axons_valid}, '0);
        check("rst_ptr", {252'd0, ptr_out}, '0);

        // 1: sixteen empty ticks, pointer wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            tick_check($sformatf("t1_%0d", i), '0, (i + 1) % 16);
        end
        step(1'b0, 1'b0, '0);
        check("t1_idle_valid", {255'd0, axons_valid}, '0);

        // 2: dt=2 axon=5 from ptr 0 -> third tick only
        step(1'b0, 1'b1, pkt(2, 5));
        tick_check("t2_a", '0, 1);
        tick_check("t2_b", '0, 2);
        tick_check("t2_c", bitv(5), 3);

        // 3: tick + dt=0 packet same cycle -> bypass into this tick
        step(1'b1, 1'b1, pkt(0, 200));
        check("t3_out", axons_out, bitv(200));
        check("t3_ptr", {252'd0, ptr_out}, 256'd4);
        step(1'b0, 1'b0, '0);
        check("t3_hold_out", axons_out, bitv(200));
        check("t3_hold_valid", {255'd0, axons_valid}, '0);
        tick_check("t3_next", '0, 5);

        // 4: advance to ptr 14, dt=3 wraps into row 1
        for (int i = 0; i < 9; i++) begin
            tick_check($sformatf("t4_adv%0d", i), '0, 6 + i);
        end
        step(1'b0, 1'b1, pkt(3, 7));
        tick_check("t4_a", '0, 15);
        tick_check("t4_b", '0, 0);
        tick_check("t4_c", '0, 1);
        tick_check("t4_d", bitv(7), 2);

        // 5: duplicate packets OR idempotently with a neighbour
        step(1'b0, 1'b1, pkt(1, 9));
        step(1'b0, 1'b1, pkt(1, 9));
        step(1'b0, 1'b1, pkt(1, 10));
        tick_check("t5_a", '0, 3);
        tick_check("t5_b", bitv(9) | bitv(10), 4);

        // dt==0 without a tick: delivered on the next tick
        step(1'b0, 1'b1, pkt(0, 3));
        tick_check("dt0_a", bitv(3), 5);

        // 6: load rows, reset mid-stream (with a tick asserted) -> all cleared
        step(1'b0, 1'b1, pkt(1, 1));
        step(1'b0, 1'b1, pkt(4, 50));
        step(1'b0, 1'b1, pkt(15, 99));
        tick_check("t6_pre", '0, 6);
        rst = 1'b0;
        step(1'b1, 1'b1, pkt(0, 77));
        rst = 1'b1;
        check("t6_rst_ptr", {252'd0, ptr_out}, '0);
        check("t6_rst_valid", {255'd0, axons_valid}, '0);
        check("t6_rst_out", axons_out, '0);
        for (int i = 0; i < 16; i++) begin
            tick_check($sformatf("t6_%0d", i), '0, (i + 1) % 16);
        end

        // dt==15: latest reachable row, arrives on the 16th tick
        step(1'b0, 1'b1, pkt(15, 255));
        for (int i = 0; i < 16; i++) begin
            tick_check($sformatf("dt15_%0d", i), (i == 15) ? bitv(255) : '0, (i + 1) % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
